// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between I-cache refill, D-cache refill and D-cache writeback.
// Fixed priority dw > dr > ic, with a forced ic grant after STARVE_LIMIT consecutive ic losses.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 32,
  parameter int BURST_LOG    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_gnt,
  output logic                  ic_rvalid,
  input  logic                  dr_req,
  input  logic [ADDR_WIDTH-1:0] dr_addr,
  output logic                  dr_gnt,
  output logic                  dr_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rlast,
  input  logic                  dw_req,
  input  logic [ADDR_WIDTH-1:0] dw_addr,
  output logic                  dw_gnt,
  output logic                  dw_wready,
  input  logic [DATA_WIDTH-1:0] dw_wdata,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  input  logic                  m_ack,
  input  logic                  m_rvalid,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_wready,
  output logic [DATA_WIDTH-1:0] m_wdata
);
  localparam int LOW = BURST_LOG + $clog2(DATA_WIDTH / 8);
  localparam int SW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] MASK = {{(ADDR_WIDTH - LOW){1'b1}}, {LOW{1'b0}}};
  typedef enum logic [1:0] {IDLE, CMD, RD, WR} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_DR, OWN_DW} owner_t;
  state_t r_state, w_next;
  owner_t r_owner, w_win;
  logic [BURST_LOG-1:0] r_cnt, w_cnt_next;
  logic [SW-1:0] r_starve, w_starve_next;
  logic [ADDR_WIDTH-1:0] r_addr, w_win_addr;
  logic r_we, w_grant, w_rd, w_wr, w_beat, w_last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_owner  <= OWN_NONE;
      r_cnt    <= '0;
      r_starve <= '0;
      r_addr   <= '0;
      r_we     <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt_next;
      r_starve <= w_starve_next;
      if (w_grant) begin
        r_owner <= w_win;
        r_addr  <= w_win_addr & MASK;
        r_we    <= w_win == OWN_DW;
      end
    end
  end
  always_comb begin
    w_win = OWN_NONE;
    if (r_starve == LIMIT && ic_req) w_win = OWN_IC;
    else if (dw_req) w_win = OWN_DW;
    else if (dr_req) w_win = OWN_DR;
    else if (ic_req) w_win = OWN_IC;
    // rst_n gating keeps the combinational grants quiet while reset is held
    w_grant    = rst_n && r_state == IDLE && w_win != OWN_NONE;
    w_win_addr = w_win == OWN_DW ? dw_addr : w_win == OWN_DR ? dr_addr : ic_addr;
    w_rd       = r_state == RD;
    w_wr       = r_state == WR;
    w_beat     = w_rd ? m_rvalid : w_wr ? m_wready : 1'b0;
    w_last     = w_beat && (&r_cnt);
    w_cnt_next = (r_state == CMD && m_ack) ? '0 : w_beat ? r_cnt + 1'b1 : r_cnt;
    w_starve_next = !w_grant ? r_starve
                  : (ic_req && w_win != OWN_IC) ? (r_starve == LIMIT ? LIMIT : r_starve + 1'b1)
                  : '0;
    w_next = r_state;
    if (r_state == IDLE && w_grant) w_next = CMD;
    else if (r_state == CMD && m_ack) w_next = r_owner == OWN_DW ? WR : RD;
    else if ((w_rd || w_wr) && w_last) w_next = IDLE;
    ic_gnt    = w_grant && w_win == OWN_IC;
    dr_gnt    = w_grant && w_win == OWN_DR;
    dw_gnt    = w_grant && w_win == OWN_DW;
    ic_rvalid = w_rd && r_owner == OWN_IC && m_rvalid;
    dr_rvalid = w_rd && r_owner == OWN_DR && m_rvalid;
    rdata     = w_rd ? m_rdata : '0;
    rlast     = w_rd && w_last;
    dw_wready = w_wr && m_wready;
    m_wdata   = w_wr ? dw_wdata : '0;
    m_req     = r_state == CMD;
    m_we      = r_we;
    m_addr    = r_addr;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single external memory port between the I-cache refill (read), D-cache refill (read) and D-cache writeback (write) channels. It sits between the cache miss handlers and the memory controller. Each granted transaction is sequenced as one command phase followed by a fixed-length data burst. Arbitration is fixed priority with an anti-starvation override for instruction fetch.

Parameters:
ADDR_WIDTH, 26, byte address width
DATA_WIDTH, 32, data beat width
BURST_LOG, 2, log2 of beats per burst (BURST = 1<<BURST_LOG)
STARVE_LIMIT, 4, consecutive I-cache losses before a forced I-cache grant

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
ic_req  in  1  I-cache refill request; held until ic_gnt
ic_addr  in  ADDR_WIDTH  I-cache burst base address
ic_gnt  out  1  one-cycle accept pulse
ic_rvalid  out  1  read beat valid to I-cache
dr_req  in  1  D-cache refill request
dr_addr  in  ADDR_WIDTH  D-cache refill base address
dr_gnt  out  1  one-cycle accept pulse
dr_rvalid  out  1  read beat valid to D-cache
rdata  out  DATA_WIDTH  shared read beat data (m_rdata passthrough)
rlast  out  1  final read beat
dw_req  in  1  D-cache writeback request
dw_addr  in  ADDR_WIDTH  writeback base address
dw_gnt  out  1  one-cycle accept pulse
dw_wready  out  1  writeback beat consumed this cycle
dw_wdata  in  DATA_WIDTH  current writeback beat
m_req  out  1  command valid to memory
m_we  out  1  command is write
m_addr  out  ADDR_WIDTH  command base address
m_ack  in  1  memory accepts command
m_rvalid  in  1  memory read beat valid
m_rdata  in  DATA_WIDTH  memory read beat
m_wready  in  1  memory accepts write beat
m_wdata  out  DATA_WIDTH  write beat (dw_wdata passthrough)

Behaviour:
- Reset: all outputs 0, state IDLE, beat counter 0, starve counter 0, owner none.
- States are IDLE, CMD, RD, WR.
- IDLE, with any req high:
  - Priority is dw > dr > ic.
  - Exception: if starve_cnt == STARVE_LIMIT and ic_req is high, ic wins.
  - Winner's gnt pulses that cycle.
  - Owner, m_addr (winner addr with low BURST_LOG+log2(DATA_WIDTH/8) bits cleared) and m_we (1 only for dw) are registered.
  - Next state is CMD.
  - Grant latency from req in IDLE is 0 cycles (combinational gnt).
- CMD: m_req=1 with stable m_addr/m_we until m_ack. On m_ack the next state is RD (read owner) or WR (dw); beat counter is cleared.
- RD:
  - m_rvalid is routed to owner's rvalid (the other rvalid stays 0); rdata = m_rdata.
  - Counter increments per m_rvalid.
  - rlast = m_rvalid when counter == BURST-1; that beat returns the FSM to IDLE.
- WR:
  - m_wdata = dw_wdata; dw_wready = m_wready.
  - Counter increments per m_wready.
  - Beat BURST-1 accepted means IDLE.
- Starve counter:
  - At each grant, if ic_req was high and ic lost, increment, saturating at STARVE_LIMIT.
  - Clear on any ic grant, or whenever ic_req is low at a grant.
- Requests arriving outside IDLE wait; no preemption, no queueing beyond held req.
- A requester dropping req before gnt is legal; it is not granted.
- m_rvalid/m_wready outside RD/WR are ignored (no output effect).
- The next grant is evaluated in the IDLE cycle after the last beat, so there is a 1-cycle bubble between bursts.
- Asynchronous reset mid-burst aborts immediately to reset values. Requesters must reissue.

Test Plan:
- Single ic read: ic_req, ic_addr=0x0000104 -> ic_gnt same cycle; m_req=1, m_we=0, m_addr=0x0000100 until m_ack; 4 m_rvalid beats D0..D3 -> ic_rvalid x4, rdata=D0..D3, rlast on 4th; IDLE next cycle.
- Simultaneous dw, dr, ic in IDLE -> dw_gnt first (m_we=1), then dr_gnt, then ic_gnt; each grant one cycle after the prior burst's last beat.
- Write backpressure: dw burst with m_wready toggling 1,0,1,0,1,1 -> dw_wready mirrors m_wready, m_wdata=dw_wdata, exactly 4 beats accepted, IDLE after 6 cycles.
- Starvation: ic_req held while dr_req re-asserts continuously -> after 4 dr grants, 5th grant goes to ic; starve_cnt returns to 0.
- Command stall: m_ack held low 10 cycles -> m_req, m_addr, m_we stable for all 10; no rvalid/wready propagated even if m_rvalid pulses.
- Reset mid-RD after 2 beats -> all outputs 0 immediately; after release with ic_req high, ic_gnt in first cycle and beat count restarts at 0.
